// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared multi-cycle memory port
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DM_STREAK);
    localparam logic [9:0] TMO_LAST     = 10'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] dm_streak;
    logic [9:0] tmo_cnt;
    logic       pick_dm;
    logic       pick_if;

    // Data side wins a tie unless it has already starved fetch for STREAK_LIMIT grants
    always_comb begin
        pick_dm = dm_req_i & (~if_req_i | (dm_streak != STREAK_LIMIT));
        pick_if = if_req_i & ~pick_dm;
    end

    assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

    // Access sequencer: grant in IDLE, hold the port in BUSY, pulse ready in DONE
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state       <= IDLE;
            dm_streak   <= '0;
            tmo_cnt     <= '0;
            err_o       <= 1'b0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
            if_ready_o  <= 1'b0;
            dm_ready_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (pick_dm) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        state       <= BUSY_DM;
                        if (!if_req_i) begin
                            dm_streak <= '0;
                        end else if (dm_streak != STREAK_LIMIT) begin
                            dm_streak <= dm_streak + 4'd1;
                        end
                    end else if (pick_if) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        state       <= BUSY_IF;
                        dm_streak   <= '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack_i) begin
                        if_data_o  <= mem_rdata_i;
                        mem_req_o  <= 1'b0;
                        if_ready_o <= 1'b1;
                        state      <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_o      <= 1'b1;
                        if_data_o  <= '0;
                        mem_req_o  <= 1'b0;
                        if_ready_o <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                        mem_req_o  <= 1'b0;
                        dm_ready_o <= 1'b1;
                        state      <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_o      <= 1'b1;
                        dm_rdata_o <= '0;
                        mem_req_o  <= 1'b0;
                        dm_ready_o <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port between two requesters: the instruction-fetch side (read only) and the data-memory side (read/write).
- Sits between the CPU datapath and a variable-latency memory. Generates the stall that freezes PC and pipeline state until the active access completes.
- Provides fixed data-side priority with an anti-starvation limit, plus an access timeout with a sticky error flag.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch is waiting (legal range 1-15)
TIMEOUT, 255, BUSY cycles without mem_ack_i before the access is aborted (legal range 1-1023)

Ports:
clk_i  in  1  clock, rising edge
start_i  in  1  synchronous active-low reset (0 = reset)
if_req_i  in  1  fetch request; held with if_addr_i until if_ready_o
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched instruction, registered, valid when if_ready_o
if_ready_o  out  1  one-cycle completion pulse, fetch side
dm_req_i  in  1  data request; held with addr/we/wdata until dm_ready_o
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_rdata_o  out  DATA_W  read data, registered, valid when dm_ready_o after a read
dm_ready_o  out  1  one-cycle completion pulse, data side
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion, one cycle
stall_o  out  1  combinational: (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o)
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (start_i=0 at an edge):
  - State goes to IDLE.
  - All registered outputs go to 0; if_data_o and dm_rdata_o go to 0.
  - Streak and timeout counters clear; err_o clears.
  - Reset during BUSY abandons the access. mem_req_o is 0 in the cycle after reset, and a late mem_ack_i is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant that requester.
  - Both requesting: grant DM, unless streak == MAX_DM_STREAK, in which case grant IF.
  - On a grant, latch the winner's addr/we/wdata into mem_*_o (mem_we_o=0 for IF), set mem_req_o=1, and enter BUSY_x. The latch happens at the next edge.
- Streak counter:
  - Increments on a DM grant made while if_req_i=1.
  - Clears on any IF grant, or on a DM grant made with if_req_i=0.
  - Saturates at MAX_DM_STREAK.
- BUSY_x:
  - mem_req_o=1 and mem_addr_o/mem_we_o/mem_wdata_o stay stable. Requester input changes are ignored.
  - The timeout counter increments every cycle.
  - mem_ack_i=1 at an edge: capture mem_rdata_i into if_data_o (BUSY_IF) or dm_rdata_o (BUSY_DM, read only; a write leaves dm_rdata_o unchanged). Then clear mem_req_o and enter DONE.
  - If the counter reaches TIMEOUT with no ack: set err_o, load 0 into the granted data register, clear mem_req_o, and enter DONE.
- DONE:
  - Exactly one of if_ready_o/dm_ready_o is 1, for one cycle. The state then returns to IDLE.
  - Requests are not evaluated in DONE.
  - A request still asserted in the following IDLE cycle is a new transaction.
- Latency:
  - Request seen at edge 0 → mem_req_o=1 from cycle 1.
  - Ack in cycle k → ready pulse in cycle k+1.
  - Minimum latency is 3 cycles (ack in cycle 1).
  - Back-to-back accesses take 1 IDLE cycle between DONE and the next BUSY.
- mem_ack_i outside BUSY_x is ignored and has no effect on err_o.
- A simultaneous ack and timeout at the same edge counts as an ack (no error).
- err_o clears only on reset.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x0000_0004, memory acks on its 2nd BUSY cycle with 0x8C22_0000 → mem_req_o high for 2 cycles with mem_addr_o=0x4 and mem_we_o=0; if_ready_o pulses 1 cycle later with if_data_o=0x8C22_0000; stall_o high from request until that pulse.
- Simultaneous requests: IF at 0x10, DM read at 0x100 → DM served first; dm_rdata_o=mem value; IF granted in the IDLE after DM's DONE.
- Starvation: if_req_i held high, DM issues 6 back-to-back writes, MAX_DM_STREAK=4 → grant order is DM, DM, DM, DM, IF, DM, DM; streak clears after the IF grant.
- Write: dm_we_i=1, addr 0x20, wdata 0xCAFE_F00D → mem_we_o=1 and mem_wdata_o=0xCAFE_F00D stable through BUSY; dm_rdata_o keeps its prior value; dm_ready_o pulses once.
- Timeout: TIMEOUT=8, no mem_ack_i → mem_req_o drops after 8 BUSY cycles; err_o=1 (sticky); if_ready_o pulses with if_data_o=0; a later ack is ignored.
- Reset mid-access: start_i=0 for one edge during BUSY_DM → mem_req_o=0 and ready outputs stay 0 next cycle; err_o=0; an ack arriving in the following cycle produces no ready pulse.
